mul_result_pack: RTL and testbench

MUL_RESULT_PACK -- requirements
Module: mul_result_pack

---
 rtl/mul_result_pack.sv | 123 ++++++++++++
 tb/tb_mul_result_pack.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_result_pack.sv
// Packs the multiplier's final fields into an IEEE-754 single result plus flags,
// registers it in one stage and queues it in a first-word-fall-through FIFO.
module mul_result_pack #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  input  logic [7:0]               Ez,
  input  logic                     underflow_case,
  input  logic                     overflow_case,
  input  logic [22:0]              mant,
  input  logic                     sign,
  input  logic                     nan_case,
  input  logic                     inf_case,
  input  logic                     zero_case,
  input  logic                     invalid_case,
  input  logic                     inexact,
  input  logic                     out_ready,
  input  logic                     flag_clr,
  output logic                     out_valid,
  output logic [31:0]              out_result,
  output logic [3:0]               out_flags,
  output logic [4:0]               status,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // flags are {invalid, overflow, underflow, inexact}
  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  flags;
  } entry_t;

  entry_t          comp_c;
  entry_t          stage;
  entry_t          hold;
  entry_t          head_c;
  entry_t          mem [DEPTH];
  logic            stage_valid;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pop_c;
  logic            full_c;
  logic            wr_c;
  logic            drop_c;
  logic [CW-1:0]   count_nxt_c;
  logic [4:0]      set_c;

  // Special operand classes dominate exponent range exceptions.
  always_comb begin
    comp_c = '0;
    if (nan_case) begin
      comp_c.result = 32'h7FC0_0000;
      comp_c.flags  = {invalid_case, 3'b000};
    end else if (inf_case) begin
      comp_c.result = {sign, 8'hFF, 23'h0};
      comp_c.flags  = {invalid_case, 3'b000};
    end else if (zero_case) begin
      comp_c.result = {sign, 31'h0};
      comp_c.flags  = 4'b0000;
    end else if (overflow_case) begin
      comp_c.result = {sign, 8'hFF, 23'h0};
      comp_c.flags  = 4'b0101;
    end else if (underflow_case || (Ez == 8'h00)) begin
      comp_c.result = {sign, 31'h0};
      comp_c.flags  = 4'b0011;
    end else begin
      comp_c.result = {sign, Ez, mant};
      comp_c.flags  = {3'b000, inexact};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stage_valid <= 1'b0;
      stage       <= '0;
    end else begin
      stage_valid <= in_valid;
      if (in_valid) stage <= comp_c;
    end
  end

  // A full FIFO still accepts the stage entry when the head leaves the same cycle.
  always_comb begin
    pop_c       = out_valid & out_ready;
    full_c      = (count == CW'(DEPTH));
    wr_c        = stage_valid & (~full_c | pop_c);
    drop_c      = stage_valid & full_c & ~pop_c;
    count_nxt_c = count + CW'(wr_c) - CW'(pop_c);
    set_c       = {drop_c, wr_c ? stage.flags : 4'b0000};
  end

  always_ff @(posedge CLK) begin
    if (wr_c) mem[wr_ptr] <= stage;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      status    <= '0;
      hold      <= '0;
    end else begin
      if (wr_c)  wr_ptr <= wr_ptr + AW'(1);
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt_c;
      out_valid <= (count_nxt_c != '0);
      status    <= (flag_clr ? 5'b00000 : status) | set_c;
      if (out_valid) hold <= mem[rd_ptr];
    end
  end

  // Head falls through from storage; the last shown head is held while empty.
  assign head_c     = out_valid ? mem[rd_ptr] : hold;
  assign out_result = head_c.result;
  assign out_flags  = head_c.flags;

endmodule

// File: tb/tb_mul_result_pack.sv
// Self-checking bench for mul_result_pack: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_mul_result_pack;

  localparam int unsigned DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  Ez = '0;
  logic        underflow_case = 1'b0;
  logic        overflow_case = 1'b0;
  logic [22:0] mant = '0;
  logic        sign = 1'b0;
  logic        nan_case = 1'b0;
  logic        inf_case = 1'b0;
  logic        zero_case = 1'b0;
  logic        invalid_case = 1'b0;
  logic        inexact = 1'b0;
  logic        out_ready = 1'b0;
  logic        flag_clr = 1'b0;
  logic        out_valid;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [4:0]  status;
  logic [$clog2(DEPTH):0] count;

  mul_result_pack #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .Ez(Ez),
    .underflow_case(underflow_case), .overflow_case(overflow_case),
    .mant(mant), .sign(sign), .nan_case(nan_case), .inf_case(inf_case),
    .zero_case(zero_case), .invalid_case(invalid_case), .inexact(inexact),
    .out_ready(out_ready), .flag_clr(flag_clr), .out_valid(out_valid),
    .out_result(out_result), .out_flags(out_flags), .status(status),
    .count(count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  ez;
    logic        unf;
    logic        ovf;
    logic [22:0] mant;
    logic        sign;
    logic        nan;
    logic        inf;
    logic        zero;
    logic        inv;
    logic        inex;
  } in_t;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  flags;
  } ent_t;

  typedef struct {
    in_t         in;
    logic [31:0] exp_result;
    logic [3:0]  exp_flags;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model state
  ent_t       q[$];
  logic       m_sv;
  ent_t       m_stage;
  logic [4:0] m_status;
  ent_t       m_last;

  function automatic ent_t compose(input in_t x);
    ent_t e;
    if (x.nan)                      e = '{32'h7FC00000, {x.inv, 3'b000}};
    else if (x.inf)                 e = '{{x.sign, 8'hFF, 23'h0}, {x.inv, 3'b000}};
    else if (x.zero)                e = '{{x.sign, 31'h0}, 4'b0000};
    else if (x.ovf)                 e = '{{x.sign, 8'hFF, 23'h0}, 4'b0101};
    else if (x.unf || x.ez == 8'h0) e = '{{x.sign, 31'h0}, 4'b0011};
    else                            e = '{{x.sign, x.ez, x.mant}, {3'b000, x.inex}};
    return e;
  endfunction

  function automatic in_t cur_in();
    in_t x;
    x = '{Ez, underflow_case, overflow_case, mant, sign, nan_case, inf_case,
          zero_case, invalid_case, inexact};
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t x, input logic v);
    in_valid       = v;
    Ez             = x.ez;
    underflow_case = x.unf;
    overflow_case  = x.ovf;
    mant           = x.mant;
    sign           = x.sign;
    nan_case       = x.nan;
    inf_case       = x.inf;
    zero_case      = x.zero;
    invalid_case   = x.inv;
    inexact        = x.inex;
  endtask

  task automatic model_edge();
    logic [4:0] s;
    s = '0;
    if (q.size() > 0 && out_ready) void'(q.pop_front());
    if (m_sv) begin
      if (q.size() < DEPTH) begin
        q.push_back(m_stage);
        s[3:0] = m_stage.flags;
      end else begin
        s[4] = 1'b1;
      end
    end
    m_status = (flag_clr ? 5'b0 : m_status) | s;
    m_sv = in_valid;
    if (in_valid) m_stage = compose(cur_in());
  endtask

  task automatic model_check();
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("count", 32'(count), 32'(q.size()));
    chk("status", 32'(status), 32'(m_status));
    if (q.size() > 0) begin
      chk("out_result", out_result, q[0].result);
      chk("out_flags", 32'(out_flags), 32'(q[0].flags));
      m_last = q[0];
    end else begin
      chk("hold_result", out_result, m_last.result);
      chk("hold_flags", 32'(out_flags), 32'(m_last.flags));
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    drive('0, 1'b0);
    out_ready = 1'b0;
    flag_clr  = 1'b0;
    #2;
    q.delete();
    m_sv = 1'b0;
    m_stage = '0;
    m_status = '0;
    m_last = '0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  function automatic in_t normal_in(input int i);
    in_t x;
    x = '0;
    x.ez = 8'(8'h10 + i);
    x.mant = 23'(i);
    return x;
  endfunction

  function automatic in_t rand_in();
    in_t x;
    int cls;
    x = '0;
    x.ez   = 8'($urandom_range(1, 254));
    x.mant = 23'($urandom);
    x.sign = 1'($urandom);
    x.inv  = 1'($urandom);
    x.inex = 1'($urandom);
    cls = int'($urandom_range(0, 15));
    case (cls)
      0: x.nan = 1'b1;
      1: x.inf = 1'b1;
      2: x.zero = 1'b1;
      3: x.ovf = 1'b1;
      4: x.unf = 1'b1;
      5: begin x.ovf = 1'b1; x.unf = 1'b1; end
      6: x.ez = 8'h00;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) x.ovf = 1'b1;
    return x;
  endfunction

  vec_t vecs[11];

  initial begin
    logic [31:0] e;
    in_t x;

    x = '0; x.ez = 8'h80;                                    vecs[0]  = '{x, 32'h40000000, 4'b0000};
    x = '0; x.ovf = 1; x.sign = 1;                           vecs[1]  = '{x, 32'hFF800000, 4'b0101};
    x = '0; x.nan = 1; x.inv = 1; x.ovf = 1; x.ez = 8'h33;   vecs[2]  = '{x, 32'h7FC00000, 4'b1000};
    x = '0; x.inf = 1; x.sign = 1; x.inex = 1;               vecs[3]  = '{x, 32'hFF800000, 4'b0000};
    x = '0; x.inf = 1; x.inv = 1; x.unf = 1;                 vecs[4]  = '{x, 32'h7F800000, 4'b1000};
    x = '0; x.zero = 1; x.sign = 1; x.inex = 1; x.ovf = 1;   vecs[5]  = '{x, 32'h80000000, 4'b0000};
    x = '0; x.unf = 1; x.ez = 8'h05; x.mant = 23'h123;       vecs[6]  = '{x, 32'h00000000, 4'b0011};
    x = '0; x.ez = 8'h00; x.sign = 1; x.mant = 23'h7FFFFF;   vecs[7]  = '{x, 32'h80000000, 4'b0011};
    x = '0; x.ovf = 1; x.unf = 1;                            vecs[8]  = '{x, 32'h7F800000, 4'b0101};
    x = '0; x.ez = 8'hFE; x.sign = 1; x.mant = 23'h7FFFFF; x.inex = 1;
                                                             vecs[9]  = '{x, 32'hFF7FFFFF, 4'b0001};
    x = '0; x.zero = 1; x.unf = 1; x.ez = 8'h00;             vecs[10] = '{x, 32'h00000000, 4'b0000};

    do_reset();

    // Directed composition table, each from reset with an idle consumer ready
    foreach (vecs[i]) begin
      do_reset();
      out_ready = 1'b1;
      drive(vecs[i].in, 1'b1);
      step();
      drive('0, 1'b0);
      chk("latency_edge1_out_valid", 32'(out_valid), 32'd0);
      step();
      chk("latency_edge2_out_valid", 32'(out_valid), 32'd1);
      chk("vec_out_result", out_result, vecs[i].exp_result);
      chk("vec_out_flags", 32'(out_flags), 32'(vecs[i].exp_flags));
      chk("vec_status", 32'(status), 32'({1'b0, vecs[i].exp_flags}));
      step();
    end

    // Overrun: six results into a stalled FIFO keep the first four
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(normal_in(i), 1'b1);
      step();
    end
    drive('0, 1'b0);
    step();
    step();
    chk("overrun_count", 32'(count), 32'd4);
    chk("overrun_status4", 32'(status[4]), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = (32'(16 + i) << 23) | 32'(i);
      chk("drain_out_valid", 32'(out_valid), 32'd1);
      chk("drain_order", out_result, e);
      step();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Full FIFO with simultaneous push and pop stays full without overrun
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(normal_in(32 + i), 1'b1);
      step();
      if (out_ready) begin
        chk("full_stream_count", 32'(count), 32'd4);
        chk("full_stream_overrun", 32'(status[4]), 32'd0);
      end
      if (q.size() == DEPTH) out_ready = 1'b1;
    end
    drive('0, 1'b0);
    repeat (6) step();

    // Clear coinciding with an underflow write: the set wins
    do_reset();
    out_ready = 1'b1;
    x = '0; x.unf = 1'b1; x.ez = 8'h01;
    drive(x, 1'b1);
    step();
    drive('0, 1'b0);
    flag_clr = 1'b1;
    step();
    chk("clr_race_status1", 32'(status[1]), 32'd1);
    step();
    chk("clr_alone_status", 32'(status), 32'd0);
    flag_clr = 1'b0;
    step();

    // Reset in the middle of traffic discards everything
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(normal_in(64 + i), 1'b1);
      step();
    end
    do_reset();
    out_ready = 1'b1;
    drive(normal_in(70), 1'b1);
    step();
    drive('0, 1'b0);
    chk("post_rst_edge1_out_valid", 32'(out_valid), 32'd0);
    step();
    chk("post_rst_edge2_out_valid", 32'(out_valid), 32'd1);
    chk("post_rst_result", out_result, (32'(16 + 70) << 23) | 32'd70);
    step();

    // Randomized traffic with phases of varying consumer availability
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int ph;
      ph = (i / 150) % 3;
      drive(rand_in(), $urandom_range(0, 3) != 0);
      case (ph)
        0: out_ready = ($urandom_range(0, 3) != 0);
        1: out_ready = ($urandom_range(0, 3) == 0);
        default: out_ready = 1'($urandom);
      endcase
      flag_clr = ($urandom_range(0, 15) == 0);
      if (i == 1600) do_reset();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
